// File: rtl/rd_empty_gen.sv
// Read-domain status for the async FIFO: synchronises the Gray write pointer into rclk
// and derives empty, almost_emp, rd_level and the Gray read pointer returned to wclk.
module rd_empty_gen #(
  parameter int RD_ADDRW    = 5,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 2
) (
  input  logic              rclk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [RD_ADDRW:0] rptr,
  input  logic [RD_ADDRW:0] wptr_gray,
  output logic [RD_ADDRW:0] rptr_gray,
  output logic              empty,
  output logic              almost_emp,
  output logic [RD_ADDRW:0] rd_level
);
  localparam int PW = RD_ADDRW + 1;
  localparam logic [PW-1:0] AE_LIM = PW'(AE_THRESH);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [PW-1:0] wq [SYNC_STAGES];
  logic [PW-1:0] wq_g;
  logic [PW-1:0] wq_bin;
  logic [PW-1:0] rptr_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] lvl_next;
  logic          rd_fire;

  // Synchroniser: bare flop chain, nothing between stages
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) wq[i] <= '0;
    end else begin
      wq[0] <= wptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) wq[i] <= wq[i-1];
    end
  end

  // Look ahead to the pointer value the read counter will hold after this edge
  always_comb begin
    wq_g       = wq[SYNC_STAGES-1];
    wq_bin     = gray2bin(wq_g);
    rd_fire    = rd_en & ~empty;
    rptr_next  = rptr + {{RD_ADDRW{1'b0}}, rd_fire};
    rgray_next = bin2gray(rptr_next);
    lvl_next   = wq_bin - rptr_next;
  end

  // Status registers
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_gray  <= '0;
      empty      <= 1'b1;
      almost_emp <= 1'b1;
      rd_level   <= '0;
    end else begin
      rptr_gray  <= rgray_next;
      empty      <= (rgray_next == wq_g);
      almost_emp <= (lvl_next <= AE_LIM);
      rd_level   <= lvl_next;
    end
  end

endmodule

// File: tb/tb_rd_empty_gen.sv
// Bench for rd_empty_gen: directed scenarios plus randomized traffic against an
// occupancy model built from delayed write-pointer history and a read counter.
module tb_rd_empty_gen;
  localparam int AW = 5;
  localparam int S  = 2;
  localparam int AE = 2;
  localparam int PW = AW + 1;

  logic          rclk = 1'b0;
  logic          rst_n;
  logic          rd_en;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr_gray;
  logic [PW-1:0] rptr_gray;
  logic          empty;
  logic          almost_emp;
  logic [PW-1:0] rd_level;

  int passed = 0;
  int total  = 0;

  logic [PW-1:0] wbin;
  logic [PW-1:0] syncq[$];
  logic [PW-1:0] m_sync;
  logic [PW-1:0] e_level;
  logic [PW-1:0] e_rgray;
  logic          e_empty;
  logic          e_ae;

  rd_empty_gen #(.RD_ADDRW(AW), .SYNC_STAGES(S), .AE_THRESH(AE)) dut (
    .rclk(rclk), .rst_n(rst_n), .rd_en(rd_en), .rptr(rptr), .wptr_gray(wptr_gray),
    .rptr_gray(rptr_gray), .empty(empty), .almost_emp(almost_emp), .rd_level(rd_level)
  );

  always #5 rclk = ~rclk;

  function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign wptr_gray = to_gray(wbin);

  task automatic model_reset();
    syncq.delete();
    for (int i = 0; i < S; i++) syncq.push_back('0);
    m_sync = '0; e_level = '0; e_empty = 1'b1; e_ae = 1'b1; e_rgray = '0;
    rptr = '0; wbin = '0;
  endtask

  // One rclk edge: the write pointer seen by the read side is the one from S edges
  // ago; the read counter advances on an accepted read; level is their distance.
  task automatic step();
    logic          fire;
    logic [PW-1:0] wcur;
    fire = rd_en & ~e_empty;
    wcur = wbin;
    @(posedge rclk);
    #1;
    m_sync = syncq.pop_front();
    syncq.push_back(wcur);
    rptr    = rptr + PW'(fire);
    e_level = m_sync - rptr;
    e_empty = (e_level == '0);
    e_ae    = (e_level <= PW'(AE));
    e_rgray = to_gray(rptr);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd_en = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge rclk); #1;
      total++;
      if ({rptr_gray, empty, almost_emp, rd_level} !== {6'd0, 1'b1, 1'b1, 6'd0}) begin
        $display("FAIL reset_hold edge%0d: got gray=%h e=%b ae=%b lvl=%0d need 0/1/1/0",
                 i, rptr_gray, empty, almost_emp, rd_level);
      end else passed++;
    end
    @(negedge rclk);
    rst_n = 1'b1;
    rd_en = 1'b0;
  endtask

  task automatic test_first_write();
    wbin = 6'd1;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if ({rptr_gray, empty, almost_emp, rd_level} !== {e_rgray, e_empty, e_ae, e_level}) begin
        $display("FAIL first_write model step%0d: got %h/%b/%b/%0d need %h/%b/%b/%0d",
                 i, rptr_gray, empty, almost_emp, rd_level, e_rgray, e_empty, e_ae, e_level);
      end else passed++;
      total++;
      if (empty !== (i < 3)) begin
        $display("FAIL first_write latency edge%0d: empty got %b need %b", i, empty, i < 3);
      end else passed++;
    end
    total++;
    if ({rd_level, almost_emp} !== {6'd1, 1'b1}) begin
      $display("FAIL first_write level: got lvl=%0d ae=%b need 1/1", rd_level, almost_emp);
    end else passed++;
  endtask

  task automatic test_fill_drain();
    wbin = 6'd32;
    repeat (3) step();
    total++;
    if ({rd_level, empty, almost_emp} !== {6'd32, 1'b0, 1'b0}) begin
      $display("FAIL full_level: got lvl=%0d e=%b ae=%b need 32/0/0", rd_level, empty, almost_emp);
    end else passed++;
    rd_en = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      total++;
      if ({rd_level, almost_emp, empty} !== {PW'(32 - i), (32 - i) <= AE, i == 32}) begin
        $display("FAIL drain read%0d: got lvl=%0d ae=%b e=%b need %0d/%b/%b",
                 i, rd_level, almost_emp, empty, 32 - i, (32 - i) <= AE, i == 32);
      end else passed++;
      total++;
      if ({rptr_gray, empty, almost_emp, rd_level} !== {e_rgray, e_empty, e_ae, e_level}) begin
        $display("FAIL drain model read%0d: got %h/%b/%b/%0d need %h/%b/%b/%0d",
                 i, rptr_gray, empty, almost_emp, rd_level, e_rgray, e_empty, e_ae, e_level);
      end else passed++;
    end
  endtask

  task automatic test_empty_read();
    logic [PW-1:0] g32;
    g32 = to_gray(6'd32);
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({rptr_gray, empty, rd_level} !== {g32, 1'b1, 6'd0}) begin
        $display("FAIL empty_read edge%0d: got gray=%h e=%b lvl=%0d need %h/1/0",
                 i, rptr_gray, empty, rd_level, g32);
      end else passed++;
    end
    rd_en = 1'b0;
  endtask

  task automatic test_wrap();
    logic [PW-1:0] exp_r [3];
    exp_r[0] = 6'd63; exp_r[1] = 6'd0; exp_r[2] = 6'd1;
    rd_en = 1'b0;
    rptr  = 6'd62;
    wbin  = 6'd1;
    repeat (3) step();
    total++;
    if ({rd_level, empty} !== {6'd3, 1'b0}) begin
      $display("FAIL wrap_level: got lvl=%0d e=%b need 3/0", rd_level, empty);
    end else passed++;
    rd_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if ({rptr_gray, rd_level, empty} !== {to_gray(exp_r[i-1]), PW'(3 - i), i == 3}) begin
        $display("FAIL wrap read%0d: got gray=%h lvl=%0d e=%b need %h/%0d/%b",
                 i, rptr_gray, rd_level, empty, to_gray(exp_r[i-1]), 3 - i, i == 3);
      end else passed++;
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    wbin = rptr + 6'd10;
    repeat (3) step();
    total++;
    if (rd_level !== 6'd10) begin
      $display("FAIL pre_reset_level: got %0d need 10", rd_level);
    end else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({rptr_gray, empty, almost_emp, rd_level} !== {6'd0, 1'b1, 1'b1, 6'd0}) begin
      $display("FAIL async_reset: got gray=%h e=%b ae=%b lvl=%0d need 0/1/1/0",
               rptr_gray, empty, almost_emp, rd_level);
    end else passed++;
    model_reset();
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (empty !== 1'b1) begin
        $display("FAIL post_reset_empty edge%0d: got %b need 1", i, empty);
      end else passed++;
    end
    wbin = 6'd5;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if ({rptr_gray, empty, almost_emp, rd_level} !== {e_rgray, e_empty, e_ae, e_level}) begin
        $display("FAIL post_reset model edge%0d: got %h/%b/%b/%0d need %h/%b/%b/%0d",
                 i, rptr_gray, empty, almost_emp, rd_level, e_rgray, e_empty, e_ae, e_level);
      end else passed++;
    end
    total++;
    if ({empty, rd_level} !== {1'b0, 6'd5}) begin
      $display("FAIL post_reset_write: got e=%b lvl=%0d need 0/5", empty, rd_level);
    end else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      // Writer-heavy first half, reader-heavy second half
      rd_en = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if (PW'(wbin - rptr) < PW'(32) && ((i < 200) ? ($urandom_range(0, 3) != 0)
                                                   : ($urandom_range(0, 3) == 0)))
        wbin = wbin + 6'd1;
      step();
      total++;
      if ({rptr_gray, empty, almost_emp, rd_level} !== {e_rgray, e_empty, e_ae, e_level}) begin
        $display("FAIL random step%0d: got %h/%b/%b/%0d need %h/%b/%b/%0d",
                 i, rptr_gray, empty, almost_emp, rd_level, e_rgray, e_empty, e_ae, e_level);
      end else passed++;
    end
    rd_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_write();
    test_fill_drain();
    test_empty_read();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
